sfp_frame_gen: RTL and testbench
================================

SFP_FRAME_GEN -- requirements
Module: sfp_frame_gen

Interface
REQ-001 SHALL have parameter DW, default 16: tx word width in bits; multiple of 8, at least 16; NB = DW/8 bytes per word.
REQ-002 SHALL have parameter PAYLOAD_LEN, default 6: payload words per frame, range 1..255.
REQ-003 SHALL have parameter IDLE_GAP, default 2: minimum idle words between frames, at least 1.
REQ-004 SHALL use one clock and a synchronous, active-high reset, as follows:
  tx_clk  in  1  transceiver TX user clock; sole clock
  reset  in  1  synchronous active-high reset
  ready  in  1  link ready (tx_reset_done); low forces output to zero
  en  in  1  frame generation enable
  mode  in  1  0 = internal counter payload; 1 = streamed payload
  s_data  in  DW  stream payload word
  s_valid  in  1  stream word valid
  s_ready  out  1  stream word accepted this cycle when s_valid is also high
  tx_data  out  DW  word to GTP; byte 0 in bits [7:0]
  tx_is_k  out  NB  per-byte K-character flag; bit i covers byte i
  frame_cnt  out  16  count of completed frames; wraps
  busy  out  1  high in any state other than IDLE

Function
REQ-005 SHALL implement the FSM states IDLE, SOF, HDR, PAY, CHK and EOF; the state register advances one state per tx_clk, subject to REQ-011.
REQ-006 tx_data and tx_is_k SHALL be registered; the word for state S SHALL appear one cycle after the state register holds S.
REQ-007 IDLE word: byte 0 = 0xBC (K28.5, is_k=1); all other bytes = 0x50 (D16.2, is_k=0).
REQ-008 SOF word: byte 0 = 0xFB (K27.7, is_k=1); other bytes 0x00. EOF word: byte 0 = 0xFD (K29.7, is_k=1); other bytes 0x00.
REQ-009 HDR word: frame_cnt zero-extended or truncated to DW bits; all is_k bits 0.
REQ-010 PAY, mode=0: word = internal DW-bit counter, which increments after each payload word, wraps, and is not cleared between frames.
REQ-011 PAY, mode=1: s_ready = (state==PAY) & ready & mode; on s_valid&s_ready, emit s_data. If s_valid is low, emit a filler word (all bytes 0x3C K28.1, all is_k 1); the payload count does not advance and the FSM stays in PAY.
REQ-012 The FSM SHALL leave PAY after exactly PAYLOAD_LEN payload words; fillers are not counted.
REQ-013 CHK word: XOR of all payload words of the current frame; cleared in SOF; all is_k bits 0.
REQ-014 IDLE -> SOF SHALL occur only when ready & en, at least IDLE_GAP IDLE words have been emitted since the last EOF or since reset, and, when mode=1, s_valid=1.
REQ-015 EOF -> IDLE; frame_cnt SHALL increment by 1 in the cycle the EOF state is left.
REQ-016 en deasserted mid-frame: the current frame SHALL complete normally, then the FSM stays in IDLE.
REQ-017 ready low in any state: next cycle tx_data=0, tx_is_k=0, FSM=IDLE, gap counter and checksum cleared, s_ready=0; an aborted frame SHALL NOT increment frame_cnt.
REQ-018 mode SHALL be sampled at SOF and held for the frame; changes mid-frame take effect at the next frame.
REQ-019 frame_cnt wraps from 0xFFFF to 0x0000.

Reset
REQ-020 reset SHALL take priority over all inputs.
REQ-021 Values after reset: tx_data=0, tx_is_k=0, FSM=IDLE, frame_cnt=0, payload counter=0, gap counter=0, checksum=0, s_ready=0, busy=0.

Structure
REQ-022 Package sfp_frame_pkg SHALL hold the state enum and the K/D byte constants K28_5=0xBC, K27_7=0xFB, K29_7=0xFD, K28_1=0x3C, D16_2=0x50.
REQ-023 The block SHALL be single-module; word formatting SHALL be one combinational function in the package, with no sub-module.

Verification
REQ-024 DW=16, PAYLOAD_LEN=2, IDLE_GAP=2, mode=0, ready=en=1 after reset -> words 0x50BC, 0x50BC, 0x00FB, 0x0000, 0x0000, 0x0001, 0x0001, 0x00FD, then frame_cnt=1. tx_is_k per word: 01, 01, 01, 00, 00, 00, 00, 01.
REQ-025 mode=1, PAYLOAD_LEN=3, s_data 0x1111 / gap / 0x2222 / 0x4444 with s_valid low for one cycle -> one 0x3C3C filler (is_k=11) between payload words, then CHK=0x7777.
REQ-026 ready dropped during PAY -> next cycle tx_data=0 and is_k=0; frame_cnt unchanged; the next frame begins with SOF and its HDR equals the old frame_cnt.
REQ-027 en dropped in HDR -> frame completes through EOF; IDLE words thereafter; busy=0.
REQ-028 DW=32 -> IDLE word 0x505050BC with is_k=0001; SOF word 0x000000FB with is_k=0001.
REQ-029 frame_cnt preset via a long run (or force) to 0xFFFF -> after the next EOF frame_cnt=0x0000 and the following HDR=0x0000.

Source files
------------

// File: rtl/sfp_frame_pkg.sv
// sfp_frame_pkg: frame FSM states, 8b/10b control bytes and the
// per-state tx word formatter used by sfp_frame_gen.
package sfp_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_HDR,
      ST_PAY,
      ST_CHK,
      ST_EOF
   } state_e;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K27_7 = 8'hFB;
   localparam logic [7:0] K29_7 = 8'hFD;
   localparam logic [7:0] K28_1 = 8'h3C;
   localparam logic [7:0] D16_2 = 8'h50;

   // Formatter builds the widest supported word; callers keep the low DW bits.
   localparam int MAX_DW = 256;
   localparam int MAX_NB = MAX_DW / 8;

   typedef struct packed {
      logic [MAX_DW-1:0] data;
      logic [MAX_NB-1:0] is_k;
   } tx_word_t;

   function automatic tx_word_t fmt_word(
      input state_e            st,
      input int                nb,
      input logic              fill,
      input logic [MAX_DW-1:0] val
   );
      tx_word_t w;
      w = '0;
      unique case (st)
         ST_IDLE: begin
            for (int i = 0; i < MAX_NB; i++) begin
               if (i < nb) w.data[8*i +: 8] = (i == 0) ? K28_5 : D16_2;
            end
            w.is_k[0] = 1'b1;
         end
         ST_SOF: begin
            w.data[7:0] = K27_7;
            w.is_k[0]   = 1'b1;
         end
         ST_EOF: begin
            w.data[7:0] = K29_7;
            w.is_k[0]   = 1'b1;
         end
         ST_PAY: begin
            if (fill) begin
               for (int i = 0; i < MAX_NB; i++) begin
                  if (i < nb) begin
                     w.data[8*i +: 8] = K28_1;
                     w.is_k[i]        = 1'b1;
                  end
               end
            end else begin
               w.data = val;
            end
         end
         default: w.data = val;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/sfp_frame_gen.sv
// sfp_frame_gen: framed test-pattern / stream generator feeding a
// GTP transmitter as SOF, header, payload, checksum, EOF words.
module sfp_frame_gen
   import sfp_frame_pkg::*;
#(
   parameter int DW          = 16,
   parameter int PAYLOAD_LEN = 6,
   parameter int IDLE_GAP    = 2
) (
   input  logic            tx_clk,
   input  logic            reset,
   input  logic            ready,
   input  logic            en,
   input  logic            mode,
   input  logic [DW-1:0]   s_data,
   input  logic            s_valid,
   output logic            s_ready,
   output logic [DW-1:0]   tx_data,
   output logic [DW/8-1:0] tx_is_k,
   output logic [15:0]     frame_cnt,
   output logic            busy
);

   localparam int NB = DW / 8;
   localparam int GW = $clog2(IDLE_GAP + 1);

   state_e            state_q, state_d;
   logic [DW-1:0]     tx_data_q, tx_data_d;
   logic [NB-1:0]     tx_is_k_q, tx_is_k_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;
   logic [DW-1:0]     ctr_q, ctr_d;
   logic [DW-1:0]     chk_q, chk_d;
   logic [7:0]        pay_cnt_q, pay_cnt_d;
   logic [GW-1:0]     gap_q, gap_d;
   logic              mode_q, mode_d;

   logic              acc;
   logic              fill;
   logic              gap_ok;
   logic [DW-1:0]     pay_word;
   logic [MAX_DW-1:0] fmt_val;
   tx_word_t          fmt_w;
   logic              unused_fmt;

   always_comb begin
      state_d     = state_q;
      frame_cnt_d = frame_cnt_q;
      ctr_d       = ctr_q;
      chk_d       = chk_q;
      pay_cnt_d   = pay_cnt_q;
      gap_d       = '0;
      mode_d      = mode_q;
      acc         = 1'b0;
      fill        = 1'b0;
      pay_word    = ctr_q;

      s_ready = (state_q == ST_PAY) && ready && mode_q;
      gap_ok  = (int'(gap_q) + 1) >= IDLE_GAP;

      // Streamed payload stalls on a filler word instead of a gap in framing.
      if (state_q == ST_PAY) begin
         if (mode_q) begin
            acc      = s_valid && s_ready;
            fill     = !acc;
            pay_word = s_data;
         end else begin
            acc = 1'b1;
         end
      end

      if (state_q == ST_HDR)      fmt_val = MAX_DW'(frame_cnt_q);
      else if (state_q == ST_CHK) fmt_val = MAX_DW'(chk_q);
      else                        fmt_val = MAX_DW'(pay_word);

      fmt_w     = fmt_word(state_q, NB, fill, fmt_val);
      tx_data_d = fmt_w.data[DW-1:0];
      tx_is_k_d = fmt_w.is_k[NB-1:0];

      unique case (state_q)
         ST_IDLE: begin
            gap_d = gap_q;
            if (int'(gap_q) < IDLE_GAP) gap_d = gap_q + 1'b1;
            if (ready && en && gap_ok && (!mode || s_valid)) state_d = ST_SOF;
         end
         ST_SOF: begin
            state_d   = ST_HDR;
            mode_d    = mode;
            chk_d     = '0;
            pay_cnt_d = '0;
         end
         ST_HDR: state_d = ST_PAY;
         ST_PAY: begin
            if (acc) begin
               chk_d     = chk_q ^ pay_word;
               pay_cnt_d = pay_cnt_q + 8'd1;
               if (!mode_q) ctr_d = ctr_q + 1'b1;
               if (pay_cnt_q == 8'(PAYLOAD_LEN - 1)) state_d = ST_CHK;
            end
         end
         ST_CHK: state_d = ST_EOF;
         ST_EOF: begin
            state_d     = ST_IDLE;
            frame_cnt_d = frame_cnt_q + 16'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      // Link not ready: abort silently, frame is neither counted nor resumed.
      if (!ready) begin
         state_d     = ST_IDLE;
         frame_cnt_d = frame_cnt_q;
         ctr_d       = ctr_q;
         chk_d       = '0;
         pay_cnt_d   = pay_cnt_q;
         gap_d       = '0;
         mode_d      = mode_q;
         tx_data_d   = '0;
         tx_is_k_d   = '0;
      end
   end

   assign unused_fmt = ^fmt_w;

   always_ff @(posedge tx_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         tx_data_q   <= '0;
         tx_is_k_q   <= '0;
         frame_cnt_q <= '0;
         ctr_q       <= '0;
         chk_q       <= '0;
         pay_cnt_q   <= '0;
         gap_q       <= '0;
         mode_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_data_q   <= tx_data_d;
         tx_is_k_q   <= tx_is_k_d;
         frame_cnt_q <= frame_cnt_d;
         ctr_q       <= ctr_d;
         chk_q       <= chk_d;
         pay_cnt_q   <= pay_cnt_d;
         gap_q       <= gap_d;
         mode_q      <= mode_d;
      end
   end

   assign tx_data   = tx_data_q;
   assign tx_is_k   = tx_is_k_q;
   assign frame_cnt = frame_cnt_q;
   assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sfp_frame_gen.sv
// Bench for sfp_frame_gen: directed frame scenarios and random
// frames checked against a frame-level reference model.
module tb_sfp_frame_gen;

   localparam int DW  = 16;
   localparam int PL  = 3;
   localparam int GAP = 2;

   localparam logic [15:0] W_IDLE = 16'h50BC;
   localparam logic [15:0] W_SOF  = 16'h00FB;
   localparam logic [15:0] W_EOF  = 16'h00FD;
   localparam logic [15:0] W_FILL = 16'h3C3C;

   logic          clk = 1'b0;
   logic          reset;
   logic          ready;
   logic          en;
   logic          mode;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic [DW-1:0] tx_data;
   logic [1:0]    tx_is_k;
   logic [15:0]   frame_cnt;
   logic          busy;

   logic          ready32;
   logic          en32;
   logic          mode32;
   logic [31:0]   s_data32;
   logic          s_valid32;
   logic          s_ready32;
   logic [31:0]   tx_data32;
   logic [3:0]    tx_is_k32;
   logic [15:0]   frame_cnt32;
   logic          busy32;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] m_fc  = '0;
   logic [15:0] m_ctr = '0;
   logic [15:0] ed[$];
   logic [1:0]  ek[$];

   always #5 clk = ~clk;

   sfp_frame_gen #(.DW(DW), .PAYLOAD_LEN(PL), .IDLE_GAP(GAP)) dut (
      .tx_clk(clk), .reset(reset), .ready(ready), .en(en), .mode(mode),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .tx_data(tx_data), .tx_is_k(tx_is_k), .frame_cnt(frame_cnt),
      .busy(busy)
   );

   sfp_frame_gen #(.DW(32), .PAYLOAD_LEN(2), .IDLE_GAP(1)) dut32 (
      .tx_clk(clk), .reset(reset), .ready(ready32), .en(en32),
      .mode(mode32), .s_data(s_data32), .s_valid(s_valid32),
      .s_ready(s_ready32), .tx_data(tx_data32), .tx_is_k(tx_is_k32),
      .frame_cnt(frame_cnt32), .busy(busy32)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      en      = 1'b0;
      s_valid = 1'b0;
      repeat (4) step();
   endtask

   task automatic exp_idle(input int n);
      for (int i = 0; i < n; i++) begin
         ed.push_back(W_IDLE);
         ek.push_back(2'b01);
      end
   endtask

   // One counter-mode frame: header is the count, payload continues the counter.
   task automatic exp_ctr_frame();
      logic [15:0] x;
      x = '0;
      ed.push_back(W_SOF); ek.push_back(2'b01);
      ed.push_back(m_fc);  ek.push_back(2'b00);
      for (int i = 0; i < PL; i++) begin
         ed.push_back(m_ctr); ek.push_back(2'b00);
         x     = x ^ m_ctr;
         m_ctr = m_ctr + 16'd1;
      end
      ed.push_back(x);     ek.push_back(2'b00);
      ed.push_back(W_EOF); ek.push_back(2'b01);
      m_fc = m_fc + 16'd1;
   endtask

   task automatic test_reset();
      reset = 1'b1; ready = 1'b1; en = 1'b1; mode = 1'b0;
      s_valid = 1'b0; s_data = '0;
      ready32 = 1'b1; en32 = 1'b0; mode32 = 1'b0;
      s_valid32 = 1'b0; s_data32 = '0;
      repeat (3) step();
      n_chk++;
      if (tx_data !== 16'h0 || tx_is_k !== 2'b00)
         $display("FAIL reset_tx: got %h/%b want 0000/00", tx_data, tx_is_k);
      else n_pass++;
      n_chk++;
      if (frame_cnt !== 16'h0 || busy !== 1'b0 || s_ready !== 1'b0)
         $display("FAIL reset_ctl: got fc=%h busy=%b srdy=%b want 0/0/0",
                  frame_cnt, busy, s_ready);
      else n_pass++;
      n_chk++;
      if (tx_data32 !== 32'h0 || tx_is_k32 !== 4'h0)
         $display("FAIL reset_dw32: got %h/%b want 0/0", tx_data32, tx_is_k32);
      else n_pass++;
      reset = 1'b0;
   endtask

   task automatic test_basic();
      int k;
      exp_idle(2);
      exp_ctr_frame();
      k = 0;
      while (ed.size() != 0) begin
         step();
         n_chk++;
         if (tx_data !== ed[0] || tx_is_k !== ek[0])
            $display("FAIL basic_w%0d: got %h/%b want %h/%b",
                     k, tx_data, tx_is_k, ed[0], ek[0]);
         else n_pass++;
         void'(ed.pop_front());
         void'(ek.pop_front());
         k++;
      end
      en = 1'b0;
      n_chk++;
      if (frame_cnt !== m_fc)
         $display("FAIL basic_fc: got %h want %h", frame_cnt, m_fc);
      else n_pass++;
   endtask

   task automatic test_stream();
      logic [15:0] sd [9];
      logic        sv [9];
      logic [15:0] xd [9];
      logic [1:0]  xk [9];
      logic        want_rdy;
      settle();
      sd = '{16'h1111, 16'h1111, 16'h1111, 16'h1111, 16'h0,
             16'h2222, 16'h4444, 16'h0, 16'h0};
      sv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      xd = '{W_IDLE, W_SOF, m_fc, 16'h1111, W_FILL,
             16'h2222, 16'h4444, 16'h7777, W_EOF};
      xk = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b11,
             2'b00, 2'b00, 2'b00, 2'b01};
      mode = 1'b1;
      en   = 1'b1;
      for (int c = 0; c < 9; c++) begin
         s_valid  = sv[c];
         s_data   = sd[c];
         want_rdy = (c >= 3 && c <= 6);
         n_chk++;
         if (s_ready !== want_rdy)
            $display("FAIL stream_srdy%0d: got %b want %b", c, s_ready, want_rdy);
         else n_pass++;
         step();
         n_chk++;
         if (tx_data !== xd[c] || tx_is_k !== xk[c])
            $display("FAIL stream_w%0d: got %h/%b want %h/%b",
                     c, tx_data, tx_is_k, xd[c], xk[c]);
         else n_pass++;
      end
      en = 1'b0; s_valid = 1'b0; mode = 1'b0;
      m_fc = m_fc + 16'd1;
      n_chk++;
      if (frame_cnt !== m_fc)
         $display("FAIL stream_fc: got %h want %h", frame_cnt, m_fc);
      else n_pass++;
   endtask

   task automatic test_ready_abort();
      settle();
      mode = 1'b0;
      en   = 1'b1;
      ed.push_back(W_IDLE);         ek.push_back(2'b01);
      ed.push_back(W_SOF);          ek.push_back(2'b01);
      ed.push_back(m_fc);           ek.push_back(2'b00);
      ed.push_back(m_ctr);          ek.push_back(2'b00);
      ed.push_back(m_ctr + 16'd1);  ek.push_back(2'b00);
      m_ctr = m_ctr + 16'd2;
      while (ed.size() != 0) begin
         step();
         n_chk++;
         if (tx_data !== ed[0] || tx_is_k !== ek[0])
            $display("FAIL abort_pre: got %h/%b want %h/%b",
                     tx_data, tx_is_k, ed[0], ek[0]);
         else n_pass++;
         void'(ed.pop_front());
         void'(ek.pop_front());
      end
      ready = 1'b0;
      step();
      n_chk++;
      if (tx_data !== 16'h0 || tx_is_k !== 2'b00)
         $display("FAIL abort_tx: got %h/%b want 0000/00", tx_data, tx_is_k);
      else n_pass++;
      n_chk++;
      if (frame_cnt !== m_fc || busy !== 1'b0 || s_ready !== 1'b0)
         $display("FAIL abort_ctl: got fc=%h busy=%b srdy=%b want fc=%h 0 0",
                  frame_cnt, busy, s_ready, m_fc);
      else n_pass++;
      ready = 1'b1;
      exp_idle(2);
      exp_ctr_frame();
      while (ed.size() != 0) begin
         step();
         n_chk++;
         if (tx_data !== ed[0] || tx_is_k !== ek[0])
            $display("FAIL abort_post: got %h/%b want %h/%b",
                     tx_data, tx_is_k, ed[0], ek[0]);
         else n_pass++;
         void'(ed.pop_front());
         void'(ek.pop_front());
      end
      en = 1'b0;
      n_chk++;
      if (frame_cnt !== m_fc)
         $display("FAIL abort_fc: got %h want %h", frame_cnt, m_fc);
      else n_pass++;
   endtask

   task automatic test_en_drop();
      int k;
      settle();
      en = 1'b1;
      exp_idle(1);
      exp_ctr_frame();
      k = 0;
      while (ed.size() != 0) begin
         step();
         n_chk++;
         if (tx_data !== ed[0] || tx_is_k !== ek[0])
            $display("FAIL endrop_w%0d: got %h/%b want %h/%b",
                     k, tx_data, tx_is_k, ed[0], ek[0]);
         else n_pass++;
         if (k == 1) begin
            en = 1'b0;
            n_chk++;
            if (busy !== 1'b1)
               $display("FAIL endrop_busy_hdr: got %b want 1", busy);
            else n_pass++;
         end
         void'(ed.pop_front());
         void'(ek.pop_front());
         k++;
      end
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++;
         if (tx_data !== W_IDLE || tx_is_k !== 2'b01 || busy !== 1'b0)
            $display("FAIL endrop_idle%0d: got %h/%b busy=%b want %h/01 busy=0",
                     i, tx_data, tx_is_k, busy, W_IDLE);
         else n_pass++;
      end
      n_chk++;
      if (frame_cnt !== m_fc)
         $display("FAIL endrop_fc: got %h want %h", frame_cnt, m_fc);
      else n_pass++;
   endtask

   task automatic test_dw32();
      n_chk++;
      if (tx_data32 !== 32'h505050BC || tx_is_k32 !== 4'b0001)
         $display("FAIL dw32_idle: got %h/%b want 505050bc/0001",
                  tx_data32, tx_is_k32);
      else n_pass++;
      en32 = 1'b1;
      step();
      step();
      en32 = 1'b0;
      n_chk++;
      if (tx_data32 !== 32'h000000FB || tx_is_k32 !== 4'b0001)
         $display("FAIL dw32_sof: got %h/%b want 000000fb/0001",
                  tx_data32, tx_is_k32);
      else n_pass++;
   endtask

   task automatic test_wrap();
      logic seen_eof;
      settle();
      force dut.frame_cnt_q = 16'hFFFF;
      step();
      release dut.frame_cnt_q;
      m_fc = 16'hFFFF;
      en = 1'b1;
      exp_idle(1);
      exp_ctr_frame();
      exp_idle(2);
      exp_ctr_frame();
      seen_eof = 1'b0;
      while (ed.size() != 0) begin
         step();
         n_chk++;
         if (tx_data !== ed[0] || tx_is_k !== ek[0])
            $display("FAIL wrap_w: got %h/%b want %h/%b",
                     tx_data, tx_is_k, ed[0], ek[0]);
         else n_pass++;
         if (ed[0] == W_EOF && !seen_eof) begin
            seen_eof = 1'b1;
            n_chk++;
            if (frame_cnt !== 16'h0000)
               $display("FAIL wrap_fc0: got %h want 0000", frame_cnt);
            else n_pass++;
         end
         void'(ed.pop_front());
         void'(ek.pop_front());
      end
      en = 1'b0;
      n_chk++;
      if (frame_cnt !== m_fc)
         $display("FAIL wrap_fc: got %h want %h", frame_cnt, m_fc);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [15:0] src[$];
      logic [15:0] w;
      logic [15:0] x;
      logic        m;
      logic        acc;
      logic        seen_sof;
      int          idles;
      int          budget;
      settle();
      en = 1'b1;
      for (int f = 0; f < 20; f++) begin
         m    = 1'($urandom_range(0, 1));
         mode = m;
         src.delete();
         ed.push_back(W_SOF); ek.push_back(2'b01);
         ed.push_back(m_fc);  ek.push_back(2'b00);
         x = '0;
         for (int i = 0; i < PL; i++) begin
            if (m) begin
               w = 16'($urandom);
               src.push_back(w);
            end else begin
               w     = m_ctr;
               m_ctr = m_ctr + 16'd1;
            end
            ed.push_back(w); ek.push_back(2'b00);
            x = x ^ w;
         end
         ed.push_back(x);     ek.push_back(2'b00);
         ed.push_back(W_EOF); ek.push_back(2'b01);
         m_fc = m_fc + 16'd1;
         idles    = 0;
         seen_sof = 1'b0;
         budget   = 0;
         while (ed.size() != 0 && budget < 300) begin
            s_valid = m && (src.size() != 0) && ($urandom_range(0, 3) != 0);
            s_data  = (src.size() != 0) ? src[0] : 16'h0;
            acc     = s_valid && s_ready;
            step();
            budget++;
            if (acc && src.size() != 0) void'(src.pop_front());
            if (!seen_sof && tx_data === W_IDLE && tx_is_k === 2'b01) begin
               idles++;
            end else if (m && seen_sof && tx_data === W_FILL &&
                         tx_is_k === 2'b11) begin
               idles = idles;
            end else begin
               n_chk++;
               if (tx_data !== ed[0] || tx_is_k !== ek[0])
                  $display("FAIL rand_f%0d_w: got %h/%b want %h/%b",
                           f, tx_data, tx_is_k, ed[0], ek[0]);
               else n_pass++;
               if (!seen_sof) begin
                  seen_sof = 1'b1;
                  mode     = ~m;
                  if (f > 0) begin
                     n_chk++;
                     if (idles < GAP)
                        $display("FAIL rand_f%0d_gap: got %0d idle words want >=%0d",
                                 f, idles, GAP);
                     else n_pass++;
                  end
               end
               void'(ed.pop_front());
               void'(ek.pop_front());
            end
         end
         if (ed.size() != 0) begin
            n_chk++;
            $display("FAIL rand_f%0d_timeout: got %0d words pending want 0",
                     f, ed.size());
            ed.delete();
            ek.delete();
         end
         n_chk++;
         if (frame_cnt !== m_fc)
            $display("FAIL rand_f%0d_fc: got %h want %h", f, frame_cnt, m_fc);
         else n_pass++;
      end
      en = 1'b0;
      s_valid = 1'b0;
      mode = 1'b0;
      settle();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stream();
      test_ready_abort();
      test_en_drop();
      test_dw32();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
